// File: rtl/sub_serial.sv
// sub_serial: bit-serial two's-complement subtractor, D = A - B - Bin.
// One full-subtractor cell plus a borrow flip-flop processes one bit per
// clock, LSB first. A start/busy/done handshake frames each operation and
// the result registers hold their value until the next operation finishes.
module sub_serial #(
    parameter int WIDTH = 4
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             START,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Bin,
    output logic [WIDTH-1:0] D,
    output logic             Bout,
    output logic             V,
    output logic             BUSY,
    output logic             DONE
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_t;

    // Full-subtractor cell: returns {borrow_out, difference_bit}.
    function automatic logic [1:0] fsub(input logic a_bit, input logic b_bit, input logic br_in);
        logic diff_bit;
        logic br_out;
        diff_bit = a_bit ^ b_bit ^ br_in;
        br_out   = (~a_bit & b_bit) | (~(a_bit ^ b_bit) & br_in);
        return {br_out, diff_bit};
    endfunction

    state_t            state_r;
    state_t            next_state_s;
    logic [WIDTH-1:0]  a_sh_r;
    logic [WIDTH-1:0]  b_sh_r;
    logic [WIDTH-2:0]  res_sh_r;
    logic              br_r;
    logic [CW-1:0]     cnt_r;
    logic              a_msb_r;
    logic              b_msb_r;
    logic [WIDTH-1:0]  d_r;
    logic              bout_r;
    logic              v_r;
    logic              busy_r;
    logic              done_r;

    logic              capture_s;
    logic              step_s;
    logic              last_s;
    logic              finish_s;
    logic [1:0]        cell_s;
    logic [WIDTH-1:0]  res_next_s;

    // Datapath for the current bit: one cell evaluation and the assembled result.
    always_comb begin
        cell_s     = fsub(a_sh_r[0], b_sh_r[0], br_r);
        res_next_s = {cell_s[0], res_sh_r};
        last_s     = (cnt_r == CW'(WIDTH - 1));
    end

    // State register; reset aborts any operation in flight.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state logic; START is only looked at in IDLE and FIN.
    always_comb begin
        next_state_s = IDLE;
        case (state_r)
            IDLE: begin
                if (START) begin
                    next_state_s = RUN;
                end else begin
                    next_state_s = IDLE;
                end
            end
            RUN: begin
                if (last_s) begin
                    next_state_s = FIN;
                end else begin
                    next_state_s = RUN;
                end
            end
            FIN: begin
                if (START) begin
                    next_state_s = RUN;
                end else begin
                    next_state_s = IDLE;
                end
            end
            default: begin
                next_state_s = IDLE;
            end
        endcase
    end

    // Control decode: operand capture, per-bit step, and result load enables.
    always_comb begin
        capture_s = 1'b0;
        step_s    = 1'b0;
        finish_s  = 1'b0;
        case (state_r)
            IDLE: begin
                capture_s = START;
            end
            RUN: begin
                step_s   = 1'b1;
                finish_s = last_s;
            end
            FIN: begin
                capture_s = START;
            end
            default: begin
                capture_s = 1'b0;
            end
        endcase
    end

    // Operand/result shift registers, borrow flip-flop and bit counter.
    always_ff @(posedge CLK) begin
        if (RST) begin
            a_sh_r   <= '0;
            b_sh_r   <= '0;
            res_sh_r <= '0;
            br_r     <= 1'b0;
            cnt_r    <= '0;
            a_msb_r  <= 1'b0;
            b_msb_r  <= 1'b0;
        end else if (capture_s) begin
            a_sh_r   <= A;
            b_sh_r   <= B;
            res_sh_r <= '0;
            br_r     <= Bin;
            cnt_r    <= '0;
            a_msb_r  <= A[WIDTH-1];
            b_msb_r  <= B[WIDTH-1];
        end else if (step_s) begin
            a_sh_r   <= {1'b0, a_sh_r[WIDTH-1:1]};
            b_sh_r   <= {1'b0, b_sh_r[WIDTH-1:1]};
            res_sh_r <= res_next_s[WIDTH-1:1];
            br_r     <= cell_s[1];
            cnt_r    <= cnt_r + CW'(1);
        end
    end

    // Result registers: updated only on the edge that enters FIN.
    always_ff @(posedge CLK) begin
        if (RST) begin
            d_r    <= '0;
            bout_r <= 1'b0;
            v_r    <= 1'b0;
        end else if (finish_s) begin
            d_r    <= res_next_s;
            bout_r <= cell_s[1];
            v_r    <= (a_msb_r != b_msb_r) && (res_next_s[WIDTH-1] != a_msb_r);
        end
    end

    // Registered handshake flags, tracking the state being entered.
    always_ff @(posedge CLK) begin
        if (RST) begin
            busy_r <= 1'b0;
            done_r <= 1'b0;
        end else begin
            busy_r <= (next_state_s == RUN);
            done_r <= (next_state_s == FIN);
        end
    end

    assign D    = d_r;
    assign Bout = bout_r;
    assign V    = v_r;
    assign BUSY = busy_r;
    assign DONE = done_r;

endmodule

// File: tb/tb_sub_serial.sv
// Directed self-checking bench for sub_serial (WIDTH = 4).
module tb_sub_serial;

    localparam int W = 4;

    logic         CLK;
    logic         RST;
    logic         START;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic         Bin;
    logic [W-1:0] D;
    logic         Bout;
    logic         V;
    logic         BUSY;
    logic         DONE;

    int checks;
    int errors;

    sub_serial #(.WIDTH(W)) dut (
        .CLK   (CLK),
        .RST   (RST),
        .START (START),
        .A     (A),
        .B     (B),
        .Bin   (Bin),
        .D     (D),
        .Bout  (Bout),
        .V     (V),
        .BUSY  (BUSY),
        .DONE  (DONE)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Issue one operation from idle and check latency, BUSY span and result.
    task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic bi, input logic [W-1:0] exp_d,
                          input logic exp_bout, input logic exp_v);
        int lat;
        int busy_cnt;
        START = 1'b1; A = a; B = b; Bin = bi;
        @(negedge CLK);
        START = 1'b0; A = 4'hx; B = 4'hx; Bin = 1'bx;
        lat = 1;
        busy_cnt = 0;
        while (!DONE && lat < 20) begin
            if (BUSY) busy_cnt++;
            @(negedge CLK);
            lat++;
        end
        check({tag, "_latency"}, 32'(lat), 32'd5);
        check({tag, "_busy_cycles"}, 32'(busy_cnt), 32'd4);
        check({tag, "_D"}, 32'(D), 32'(exp_d));
        check({tag, "_Bout"}, 32'(Bout), 32'(exp_bout));
        check({tag, "_V"}, 32'(V), 32'(exp_v));
        @(negedge CLK);
        check({tag, "_done_drop"}, 32'(DONE), 32'd0);
        check({tag, "_D_hold"}, 32'(D), 32'(exp_d));
    endtask

    initial begin
        int dones;
        checks = 0;
        errors = 0;
        RST = 1'b1; START = 1'b0; A = 4'h0; B = 4'h0; Bin = 1'b0;
        @(negedge CLK);
        @(negedge CLK);
        check("rst_D", 32'(D), 32'd0);
        check("rst_Bout", 32'(Bout), 32'd0);
        check("rst_V", 32'(V), 32'd0);
        check("rst_BUSY", 32'(BUSY), 32'd0);
        check("rst_DONE", 32'(DONE), 32'd0);
        RST = 1'b0;
        @(negedge CLK);

        run_op("t1_3m1", 4'b0011, 4'b0001, 1'b0, 4'b0010, 1'b0, 1'b0);
        run_op("t2_0m1", 4'b0000, 4'b0001, 1'b0, 4'b1111, 1'b1, 1'b0);
        run_op("t4a_0m0b1", 4'b0000, 4'b0000, 1'b1, 4'b1111, 1'b1, 1'b0);
        run_op("t4b_fmfb1", 4'b1111, 4'b1111, 1'b1, 4'b1111, 1'b1, 1'b0);

        // Back-to-back: START held through the first op, operands changed mid-flight.
        START = 1'b1; A = 4'b0101; B = 4'b0010; Bin = 1'b0;
        @(negedge CLK);
        check("b2b_busy1", 32'(BUSY), 32'd1);
        @(negedge CLK);
        A = 4'b1111; B = 4'b0001;
        @(negedge CLK);
        check("b2b_nodone3", 32'(DONE), 32'd0);
        @(negedge CLK);
        check("b2b_nodone4", 32'(DONE), 32'd0);
        @(negedge CLK);
        check("b2b_done1", 32'(DONE), 32'd1);
        check("b2b_D1", 32'(D), 32'b0011);
        check("b2b_Bout1", 32'(Bout), 32'd0);
        check("b2b_V1", 32'(V), 32'd0);
        @(negedge CLK);
        START = 1'b0;
        check("b2b_busy_again", 32'(BUSY), 32'd1);
        check("b2b_done_once", 32'(DONE), 32'd0);
        @(negedge CLK);
        check("b2b_nodone7", 32'(DONE), 32'd0);
        @(negedge CLK);
        check("b2b_nodone8", 32'(DONE), 32'd0);
        @(negedge CLK);
        check("b2b_nodone9", 32'(DONE), 32'd0);
        check("b2b_D_held", 32'(D), 32'b0011);
        @(negedge CLK);
        check("b2b_done2", 32'(DONE), 32'd1);
        check("b2b_D2", 32'(D), 32'b1110);
        check("b2b_Bout2", 32'(Bout), 32'd0);
        check("b2b_V2", 32'(V), 32'd0);
        @(negedge CLK);
        check("b2b_done2_drop", 32'(DONE), 32'd0);
        check("b2b_idle", 32'(BUSY), 32'd0);

        run_op("t3_7m8", 4'b0111, 4'b1000, 1'b0, 4'b1111, 1'b1, 1'b1);

        // Reset in the second RUN cycle aborts the operation.
        START = 1'b1; A = 4'b0011; B = 4'b0001; Bin = 1'b0;
        @(negedge CLK);
        START = 1'b0;
        @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        check("abort_D", 32'(D), 32'd0);
        check("abort_Bout", 32'(Bout), 32'd0);
        check("abort_V", 32'(V), 32'd0);
        check("abort_BUSY", 32'(BUSY), 32'd0);
        dones = 0;
        for (int i = 0; i < 8; i++) begin
            if (DONE) dones++;
            @(negedge CLK);
        end
        check("abort_no_done", 32'(dones), 32'd0);

        run_op("after_abort", 4'b0011, 4'b0001, 1'b0, 4'b0010, 1'b0, 1'b0);

        // RST and START together: START is dropped.
        RST = 1'b1; START = 1'b1; A = 4'b0110; B = 4'b0001; Bin = 1'b0;
        @(negedge CLK);
        RST = 1'b0; START = 1'b0;
        check("rst_start_BUSY", 32'(BUSY), 32'd0);
        check("rst_start_D", 32'(D), 32'd0);
        @(negedge CLK);
        check("rst_start_idle", 32'(BUSY), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, errors);
        $finish;
    end

endmodule

// File: doc/sub_serial.md
Name: sub_serial

Overview:
- Bit-serial two's-complement subtractor, the inverse operation of the team's ripple adder family (ADDER4 style, A/B/carry in, S/Cout).
- Computes D = A − B − Bin one bit per clock, LSB first, using a single full-subtractor cell and a borrow flip-flop.
- Start/busy/done handshake; result registers hold until the next operation.
- Used where area matters more than latency, and as a sequential companion to the combinational adders in the lab datapath.

Parameters:
- WIDTH, 4, operand and result width in bits (legal ≥ 2).

Ports:
- CLK  input  1  system clock, rising-edge active.
- RST  input  1  synchronous reset, active-high.
- START  input  1  request; sampled only while not BUSY.
- A  input  WIDTH  minuend; captured on accepted START.
- B  input  WIDTH  subtrahend; captured on accepted START.
- Bin  input  1  borrow in; captured on accepted START.
- D  output  WIDTH  difference, registered.
- Bout  output  1  borrow out (1 when unsigned A < B + Bin), registered.
- V  output  1  signed overflow flag, registered.
- BUSY  output  1  high while in RUN.
- DONE  output  1  one-cycle pulse when D/Bout/V are updated.

Behaviour:
- Interface: one clock domain. RST is synchronous and active-high: sampled on the rising edge of CLK, with no asynchronous path.
- Reset values: D = 0, Bout = 0, V = 0, BUSY = 0, DONE = 0, state = IDLE, internal registers = 0.
- FSM states: IDLE, RUN, FIN.
  - IDLE: START = 1 at an edge captures A, B, Bin into shift registers and the borrow flip-flop, clears the bit counter, and moves to RUN.
  - RUN: each edge computes one bit.
    - d_i = a_i ^ b_i ^ br
    - br' = (~a_i & b_i) | (~(a_i ^ b_i) & br)
    - d_i shifts into the result shift register MSB-side; the operands shift right.
    - The counter increments; after the WIDTH-th RUN edge, go to FIN.
    - At that same edge, load D from the shift register, set Bout = final br, and compute V.
  - FIN: DONE = 1 for exactly this cycle.
    - START = 1 here is accepted exactly as in IDLE, going directly to RUN (back-to-back operation).
    - Otherwise return to IDLE.
- Latency: START sampled at edge n → DONE high in the cycle after edge n + WIDTH, i.e. WIDTH + 1 cycles from request to result.
- Throughput: one result every WIDTH + 1 cycles.
- BUSY = 1 exactly while state = RUN. START while BUSY is ignored: no capture, no effect on the in-flight operation.
- A, B and Bin are don't-care except at the accepting edge.
- D, Bout and V change only at the edge entering FIN (or on reset). They hold between operations.
- Overflow: V = (A[WIDTH-1] != B[WIDTH-1]) && (D[WIDTH-1] != A[WIDTH-1]), using the captured operand sign bits. Bin does not enter the V formula.
- Wrap-around: arithmetic is modulo 2^WIDTH. Bout reports the unsigned underflow.
- Reset mid-operation: RST wins over all other inputs at that edge.
  - Abort, go to IDLE, and zero the outputs.
  - No DONE pulse is produced for the aborted operation.
- RST and START at the same edge: reset takes priority and START is dropped.

Test Plan:
- A=0011, B=0001, Bin=0, START for 1 cycle → BUSY high 4 cycles; DONE pulses 5 cycles after the request; D=0010, Bout=0, V=0.
- A=0000, B=0001, Bin=0 → D=1111, Bout=1, V=0.
- A=0111, B=1000, Bin=0 → D=1111, Bout=1, V=1 (7 − (−8) overflows).
- A=0000, B=0000, Bin=1 → D=1111, Bout=1, V=0. Then A=1111, B=1111, Bin=1 → D=1111, Bout=1, V=0.
- Hold START high continuously with A=0101, B=0010, then change the operands to A=1111, B=0001 two cycles in:
  - The first op still gives D=0011.
  - START during the FIN cycle is accepted with A=1111, B=0001, giving D=1110 five cycles later.
  - Check exactly one DONE pulse per operation.
- Start A=0011, B=0001, then assert RST at the 2nd RUN cycle → all outputs 0 at the next edge and no DONE. A following START still completes correctly.
